// File: rtl/wifi_tx_pkg.sv
// Shared definitions for the multirate transmit puncturer: rate codes,
// FSM states and the per-rate puncture period and keep patterns.
package wifi_tx_pkg;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'b00,
    RATE_2_3  = 2'b01,
    RATE_3_4  = 2'b10,
    RATE_RSVD = 2'b11
  } rate_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [1:0] PERIOD_1_2 = 2'd1;
  localparam logic [1:0] PERIOD_2_3 = 2'd2;
  localparam logic [1:0] PERIOD_3_4 = 2'd3;

  function automatic logic [1:0] punct_period(rate_e r);
    case (r)
      RATE_2_3: return PERIOD_2_3;
      RATE_3_4: return PERIOD_3_4;
      default:  return PERIOD_1_2;
    endcase
  endfunction

  // Keep mask per phase: bit0 keeps A, bit1 keeps B.
  function automatic logic [1:0] keep_mask(rate_e r, logic [1:0] ph);
    case (r)
      RATE_2_3: return (ph == 2'd0) ? 2'b11 : 2'b01;
      RATE_3_4: return (ph == 2'd0) ? 2'b11 : ((ph == 2'd1) ? 2'b01 : 2'b10);
      default:  return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/wifi_tx_puncturer_multirate_if.sv
// Pair-in / serial-bit-out handshake bundle of the puncturer.
interface wifi_tx_puncturer_multirate_if;
  logic       valid_in;
  logic [1:0] data_in;
  logic       last_in;
  logic       ready_in;
  logic       data_out;
  logic       valid_out;
  logic       finished;

  modport master (
    output valid_in, data_in, last_in,
    input  ready_in, data_out, valid_out, finished
  );

  modport slave (
    input  valid_in, data_in, last_in,
    output ready_in, data_out, valid_out, finished
  );
endinterface

// File: rtl/wifi_tx_bit_fifo.sv
// Bit FIFO taking 1 or 2 bits per write and yielding 1 bit per read;
// an empty FIFO forwards the first written bit straight to rd_data.
module wifi_tx_bit_fifo import wifi_tx_pkg::*; #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [1:0]                         wr_cnt,
  input  logic [1:0]                         wr_data,
  input  logic                               rd_en,
  output logic                               rd_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [FIFO_DEPTH-1:0] mem;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [1:0]            wr_num;

  always_comb begin
    wr_num  = wr_en ? wr_cnt : 2'd0;
    rd_data = (count == '0) ? wr_data[0] : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data[0];
      if (wr_cnt[1]) mem[wr_ptr + AW'(1)] <= wr_data[1];
    end
  end

  // Bypass read still advances rd_ptr past the slot written this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_num);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count  <= count + CW'(wr_num) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/wifi_tx_puncturer_multirate.sv
// Multirate convolutional-code puncturer: accepts A/B encoder pairs, keeps
// bits per the latched rate's pattern and streams them out serially.
module wifi_tx_puncturer_multirate import wifi_tx_pkg::*; #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [1:0]  DEFAULT_RATE = 2'b00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         start,
  input  logic [1:0]                   rate_sel,
  wifi_tx_puncturer_multirate_if.slave bus
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  state_e        state_q, state_d;
  rate_e         rate_q;
  logic [1:0]    phase_q;
  logic [CW-1:0] count;
  logic [CW:0]   free_slots;
  logic          fifo_nonempty, accept, rd_en, rd_data;
  logic [1:0]    mask, wr_cnt, wr_data;

  always_comb begin
    fifo_nonempty = (count != '0);
    // A non-empty FIFO frees one slot this cycle through its read.
    free_slots    = (CW+1)'(FIFO_DEPTH) - {1'b0, count} + (CW+1)'(fifo_nonempty);
    bus.ready_in  = (state_q == ST_RUN) && enable && (free_slots >= (CW+1)'(2));
    accept        = bus.ready_in && bus.valid_in;
    mask          = keep_mask(rate_q, phase_q);
    wr_cnt        = {1'b0, mask[0]} + {1'b0, mask[1]};
    wr_data       = mask[0] ? bus.data_in : {1'b0, bus.data_in[1]};
    rd_en         = enable && (fifo_nonempty || accept);
    bus.finished  = (state_q == ST_DONE) && enable;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable && start) state_d = ST_RUN;
      ST_RUN:   if (accept && bus.last_in) state_d = ST_DRAIN;
      ST_DRAIN: if (enable && !fifo_nonempty) state_d = ST_DONE;
      ST_DONE:  if (enable) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rate_q  <= rate_e'(DEFAULT_RATE);
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && enable && start) begin
        rate_q  <= rate_e'(rate_sel);
        phase_q <= '0;
      end else if (accept) begin
        phase_q <= (phase_q + 2'd1 == punct_period(rate_q)) ? 2'd0 : phase_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.data_out  <= 1'b0;
      bus.valid_out <= 1'b0;
    end else if (enable) begin
      bus.valid_out <= rd_en;
      bus.data_out  <= rd_en & rd_data;
    end else begin
      bus.valid_out <= 1'b0;
    end
  end

  wifi_tx_bit_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_cnt  (wr_cnt),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count)
  );

endmodule

// File: tb/tb_wifi_tx_puncturer_multirate.sv
// Self-checking bench: directed frames plus randomized frames, compared
// cycle by cycle against a queue-based reference model of the puncturer.
module tb_wifi_tx_puncturer_multirate;
  localparam int unsigned DEPTH    = 4;
  localparam logic [1:0]  DEF_RATE = 2'b00;
  localparam int IDLE = 0, RUN = 1, DRAIN = 2, DONE = 3;

  logic       clk = 1'b0;
  logic       reset, enable, start;
  logic [1:0] rate_sel;

  wifi_tx_puncturer_multirate_if bus();

  wifi_tx_puncturer_multirate #(.FIFO_DEPTH(DEPTH), .DEFAULT_RATE(DEF_RATE)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .rate_sel (rate_sel),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model state
  int         m_state = IDLE, m_phase = 0, m_rate = int'(DEF_RATE);
  bit         q[$];
  bit         exp_valid = 0, exp_data = 0;
  bit         got_q[$], exp_bits[$], saved_q[$];
  logic [1:0] frame_q[$];
  int         fin_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Kept bits of a pair: 1 = A only, 2 = B only, 3 = both.
  function automatic int kept(int rate, int ph);
    if (rate == 1) return (ph == 0) ? 3 : 1;
    if (rate == 2) return (ph == 0) ? 3 : ((ph == 1) ? 1 : 2);
    return 3;
  endfunction

  function automatic int period(int rate);
    return (rate == 1) ? 2 : ((rate == 2) ? 3 : 1);
  endfunction

  function automatic int frame_bits(int rate);
    int n = 0;
    for (int i = 0; i < frame_q.size(); i++) n += (kept(rate, i % period(rate)) == 3) ? 2 : 1;
    return n;
  endfunction

  task automatic cycle(input bit rst_n, input bit en, input bit st, input logic [1:0] rs,
                       input bit v, input logic [1:0] d, input bit l, output bit acc);
    bit m_ready;
    int occ, k;
    reset = rst_n; enable = en; start = st; rate_sel = rs;
    bus.valid_in = v; bus.data_in = d; bus.last_in = l;
    #2;
    occ     = q.size();
    m_ready = (m_state == RUN) && en && (int'(DEPTH) - occ + ((occ != 0) ? 1 : 0) >= 2);
    check_eq("ready_in", bus.ready_in, m_ready);
    acc = 0;
    if (!rst_n) begin
      m_state = IDLE; m_phase = 0; m_rate = int'(DEF_RATE);
      q.delete(); exp_valid = 0; exp_data = 0;
    end else if (en) begin
      acc = m_ready && v;
      if (acc) begin
        k = kept(m_rate, m_phase);
        if (k != 2) q.push_back(d[0]);
        if (k != 1) q.push_back(d[1]);
      end
      if (q.size() != 0) begin exp_valid = 1; exp_data = q.pop_front(); end
      else begin exp_valid = 0; exp_data = 0; end
      case (m_state)
        IDLE:  if (st) begin m_state = RUN; m_phase = 0; m_rate = int'(rs); end
        RUN:   if (acc) begin
                 m_phase = (m_phase + 1) % period(m_rate);
                 if (l) m_state = DRAIN;
               end
        DRAIN: if (occ == 0) m_state = DONE;
        default: m_state = IDLE;
      endcase
    end else begin
      exp_valid = 0;
    end
    @(posedge clk); #1;
    check_eq("valid_out", bus.valid_out, exp_valid);
    check_eq("data_out", bus.data_out, exp_data);
    check_eq("finished", bus.finished, (m_state == DONE) && en);
    if (bus.valid_out) got_q.push_back(bus.data_out);
    if (bus.finished) fin_count++;
  endtask

  task automatic feed_pairs(input logic [1:0] rs, input int stall_at, input int stall_len, input bit noise);
    int  idx = 0, cyc = 0, n = frame_q.size();
    bit  acc, en, v;
    got_q.delete(); fin_count = 0;
    cycle(1, 1, 1, rs, 0, 2'b00, 0, acc);
    while (idx < n && cyc < 300) begin
      en = !(cyc >= stall_at && cyc < stall_at + stall_len);
      v  = 1;
      if (noise) begin
        if ($urandom_range(9) == 0) en = 0;
        v = ($urandom_range(3) != 0);
      end
      cycle(1, en, cyc[0], 2'($urandom), v, v ? frame_q[idx] : 2'($urandom), idx == n - 1, acc);
      if (acc) idx++;
      cyc++;
    end
    if (idx < n) check_eq("feed_timeout", idx, n);
  endtask

  task automatic send_frame(input logic [1:0] rs, input int stall_at, input int stall_len, input bit noise);
    int cyc = 0;
    bit acc, en;
    feed_pairs(rs, stall_at, stall_len, noise);
    while (fin_count == 0 && cyc < 100) begin
      en = noise ? ($urandom_range(4) != 0) : 1'b1;
      cycle(1, en, 0, 2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), acc);
      cyc++;
    end
    cycle(1, 1, 0, 2'b00, 0, 2'b00, 0, acc);
    check_eq("finished_count", fin_count, 1);
    check_eq("bit_count", got_q.size(), frame_bits((rs == 2'b11) ? 0 : int'(rs)));
  endtask

  task automatic cmp_seq(input string tag);
    check_eq({tag, "_len"}, got_q.size(), exp_bits.size());
    for (int i = 0; i < exp_bits.size() && i < got_q.size(); i++)
      check_eq(tag, got_q[i], exp_bits[i]);
  endtask

  initial begin
    bit acc;
    int k;
    logic [1:0] rs;
    reset = 0; enable = 1; start = 0; rate_sel = 0;
    bus.valid_in = 0; bus.data_in = 0; bus.last_in = 0;
    @(posedge clk); #1;
    cycle(0, 1, 0, 2'b00, 1, 2'b11, 0, acc);
    cycle(0, 1, 1, 2'b10, 1, 2'b11, 1, acc);
    cycle(1, 1, 0, 2'b00, 1, 2'b11, 1, acc);

    // Rate 3/4: (1,0),(1,1),(0,1)
    frame_q = '{2'b01, 2'b11, 2'b10};
    exp_bits = '{1, 0, 1, 1};
    send_frame(2'b10, 1000, 0, 0);
    cmp_seq("r34_seq");
    saved_q = got_q;

    // Same frame with a 3-cycle enable stall
    send_frame(2'b10, 1, 3, 0);
    exp_bits = saved_q;
    cmp_seq("r34_stall_seq");

    // Rate 2/3: (1,1),(0,1),(1,0),(1,1)
    frame_q = '{2'b11, 2'b10, 2'b01, 2'b11};
    exp_bits = '{1, 1, 0, 1, 0, 1};
    send_frame(2'b01, 1000, 0, 0);
    cmp_seq("r23_seq");

    // Rate 1/2, 8 pairs back to back into a 4-bit FIFO
    frame_q.delete();
    exp_bits.delete();
    for (int i = 0; i < 8; i++) begin
      frame_q.push_back(2'($urandom));
      exp_bits.push_back(frame_q[i][0]);
      exp_bits.push_back(frame_q[i][1]);
    end
    send_frame(2'b00, 1000, 0, 0);
    cmp_seq("r12_seq");

    // Reset while draining with 3 bits buffered
    feed_pairs(2'b00, 1000, 0, 0);
    k = 0;
    while (q.size() > 3 && k < 20) begin
      cycle(1, 1, 0, 2'b00, 0, 2'b00, 0, acc);
      k++;
    end
    cycle(0, 1, 0, 2'b00, 1, 2'b11, 0, acc);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 2'b00, 1, 2'b11, 1, acc);
    check_eq("no_finish_after_reset", fin_count, 0);
    frame_q = '{2'b11, 2'b10, 2'b01, 2'b11};
    exp_bits = '{1, 1, 0, 1, 0, 1};
    send_frame(2'b01, 1000, 0, 0);
    cmp_seq("post_reset_seq");

    // Reserved rate code behaves as 1/2; start pulses during RUN ignored
    frame_q = '{2'b10, 2'b01};
    exp_bits = '{0, 1, 1, 0};
    send_frame(2'b11, 1000, 0, 0);
    cmp_seq("r11_seq");

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      frame_q.delete();
      k = $urandom_range(10, 1);
      for (int i = 0; i < k; i++) frame_q.push_back(2'($urandom));
      rs = 2'($urandom);
      send_frame(rs, $urandom_range(8), $urandom_range(3), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
